dx_spi_ctrl: RTL and testbench

DX_SPI_CTRL -- requirements
Module: dx_spi_ctrl

---
 rtl/dx_spi_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_dx_spi_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dx_spi_ctrl.sv
// dx_spi_ctrl -- two-requester SPI master (mode 0, MSB first).
//
// Purpose: arbitrates between two requesters, then runs one SPI
// transaction per accept: SETUP -> SHIFT -> HOLD -> GAP -> IDLE. Each of
// SETUP, HOLD and GAP lasts CLK_DIV cycles. SHIFT lasts 2*DATA_WIDTH*CLK_DIV
// cycles. The captured miso word is returned with a one-cycle rsp_valid pulse
// on the first GAP cycle.
//
// Build option: define DX_SPI_CTRL_RR_EN for round-robin arbitration.
// Without it, req0 has fixed priority over req1 and there is no last-grant
// register.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready/cs/data   requester N (N=0,1) transaction handshake
//   rsp_valid/rsp_id/rsp_data  response pulse, owner id, captured miso word
//   sclk, mosi, miso, csn      SPI pins (csn active low, one per target)
//   busy                       high whenever the FSM is not IDLE
//
// Handshake: a transfer happens on a rising clk edge when reqN_valid and
// reqN_ready are both high. reqN_ready is combinational from the valids.
// It is only high in IDLE, and only for the granted requester. The
// requester must not depend on ready before asserting valid.
//
// DATA_WIDTH must be at least 2, and CLK_DIV must be in the range 1..255.
module dx_spi_ctrl #(
  parameter int CSN_NUM    = 8,
  parameter int CS_WIDTH   = 3,
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [CS_WIDTH-1:0]   req0_cs,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [CS_WIDTH-1:0]   req1_cs,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic [CSN_NUM-1:0]    csn,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam int HALF_W = $clog2(2 * DATA_WIDTH);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_WIDTH - 1);
  localparam logic [7:0] CNT_LOAD = 8'(CLK_DIV - 1);

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [HALF_W-1:0]     half_q, half_d;
  logic                  id_q, id_d;
  logic                  bad_q, bad_d;
  logic [DATA_WIDTH-2:0] tx_q, tx_d;   // bits still to send after mosi
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [CSN_NUM-1:0]    csn_q, csn_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  busy_q, busy_d;

  // Grant selection.
  logic                  any_valid;
  logic                  grant_id;
  logic [CS_WIDTH-1:0]   grant_cs;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  grant_bad;
  logic [CSN_NUM-1:0]    grant_csn;

`ifdef DX_SPI_CTRL_RR_EN
  logic last_q, last_d;
  // When both requesters are valid, the one not granted last wins.
  always_comb begin
    if (req0_valid && req1_valid) grant_id = ~last_q;
    else                          grant_id = req1_valid;
  end
`else
  always_comb grant_id = req1_valid && !req0_valid;
`endif

  always_comb begin
    any_valid  = req0_valid || req1_valid;
    grant_cs   = grant_id ? req1_cs   : req0_cs;
    grant_data = grant_id ? req1_data : req0_data;
    // An index past the last chip select addresses nothing. The transaction
    // still runs with full timing, but its response data is forced to zero.
    grant_bad  = 32'(grant_cs) >= 32'(CSN_NUM);
    for (int i = 0; i < CSN_NUM; i++) grant_csn[i] = (32'(grant_cs) != 32'(i));
  end

  assign req0_ready = (state_q == IDLE) && any_valid && !grant_id;
  assign req1_ready = (state_q == IDLE) && any_valid &&  grant_id;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    id_d        = id_q;
    bad_d       = bad_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    csn_d       = csn_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
`ifdef DX_SPI_CTRL_RR_EN
    last_d      = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d = SETUP;
          cnt_d   = CNT_LOAD;
          id_d    = grant_id;
          bad_d   = grant_bad;
          csn_d   = grant_csn;
          mosi_d  = grant_data[DATA_WIDTH-1];
          tx_d    = grant_data[DATA_WIDTH-2:0];
`ifdef DX_SPI_CTRL_RR_EN
          last_d  = grant_id;
`endif
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          // The first rising sclk edge coincides with SHIFT entry, so the
          // last SHIFT half-period is low and SHIFT ends with sclk low.
          state_d = SHIFT;
          cnt_d   = CNT_LOAD;
          half_d  = '0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[DATA_WIDTH-2:0], miso};
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      SHIFT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (half_q == HALF_LAST) begin
          state_d = HOLD;
          cnt_d   = CNT_LOAD;
          mosi_d  = 1'b0;
        end else begin
          cnt_d  = CNT_LOAD;
          half_d = half_q + HALF_W'(1);
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            // Falling edge: present the next bit.
            mosi_d = tx_q[DATA_WIDTH-2];
            tx_d   = tx_q << 1;
          end else begin
            // Rising edge: sample miso into the LSB.
            rx_d = {rx_q[DATA_WIDTH-2:0], miso};
          end
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d     = GAP;
          cnt_d       = CNT_LOAD;
          csn_d       = '1;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = bad_q ? '0 : rx_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      half_q      <= '0;
      id_q        <= 1'b0;
      bad_q       <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      csn_q       <= '1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
`ifdef DX_SPI_CTRL_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      id_q        <= id_d;
      bad_q       <= bad_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      csn_q       <= csn_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
`ifdef DX_SPI_CTRL_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign csn       = csn_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dx_spi_ctrl.sv
// Testbench for dx_spi_ctrl.
// The dut instance uses CSN_NUM=8. The dut6 instance uses CSN_NUM=6 and
// covers an out-of-range chip select. A small SPI slave model drives miso.
module tb_dx_spi_ctrl;
  localparam int CD  = 2;
  localparam int DW  = 16;
  localparam int LAT = 1 + CD * (2 + 2 * DW);   // accept -> rsp_valid
  localparam int CSN_LOW = CD * (2 + 2 * DW);   // SETUP + SHIFT + HOLD

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (8 chip selects)
  logic          req0_valid = 0, req1_valid = 0;
  logic          req0_ready, req1_ready;
  logic [2:0]    req0_cs = 0, req1_cs = 0;
  logic [DW-1:0] req0_data = 0, req1_data = 0;
  logic          rsp_valid, rsp_id, sclk, mosi, busy;
  logic [DW-1:0] rsp_data;
  logic [7:0]    csn;
  logic          miso;

  // Second DUT (6 chip selects)
  logic          r0v6 = 0;
  logic          r0r6, r1r6;
  logic [2:0]    r0cs6 = 0;
  logic [DW-1:0] r0d6 = 0;
  logic          rv6, rid6, sclk6, mosi6, busy6;
  logic [DW-1:0] rd6;
  logic [5:0]    csn6;

  dx_spi_ctrl #(.CSN_NUM(8), .CS_WIDTH(3), .DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cs(req0_cs), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cs(req1_cs), .req1_data(req1_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .sclk(sclk), .mosi(mosi), .miso(miso), .csn(csn), .busy(busy));

  dx_spi_ctrl #(.CSN_NUM(6), .CS_WIDTH(3), .DATA_WIDTH(DW), .CLK_DIV(CD)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v6), .req0_ready(r0r6), .req0_cs(r0cs6), .req0_data(r0d6),
    .req1_valid(1'b0), .req1_ready(r1r6), .req1_cs(3'd0), .req1_data('0),
    .rsp_valid(rv6), .rsp_id(rid6), .rsp_data(rd6),
    .sclk(sclk6), .mosi(mosi6), .miso(miso), .csn(csn6), .busy(busy6));

  // SPI slave model for mode 0: MSB first, with the next bit presented on
  // each falling sclk edge.
  logic [DW-1:0] slave_word = '0;
  int            bit_idx = 0;
  int            rise_cnt = 0;
  logic [DW-1:0] mosi_cap = '0;
  always_comb miso = (bit_idx < DW) ? slave_word[4'(DW - 1 - bit_idx)] : 1'b0;
  always @(negedge sclk) bit_idx = bit_idx + 1;
  always @(posedge sclk) begin
    mosi_cap = {mosi_cap[DW-2:0], mosi};
    rise_cnt = rise_cnt + 1;
  end

  int checks = 0;
  int failures = 0;
  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; r0v6 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one transaction on the main DUT. lat counts cycles from the accept
  // cycle (0) to the rsp_valid cycle. A timeout leaves lat at the bound,
  // and that value then fails the latency comparison.
  task automatic run_txn(input bit who, input logic [2:0] cs, input logic [DW-1:0] d,
                         input logic [DW-1:0] sw, output int lat, output bit rdy,
                         output int csn_low, output logic [7:0] csn_first);
    slave_word = sw; bit_idx = 0; mosi_cap = '0; rise_cnt = 0;
    lat = 0; csn_low = 0; csn_first = '1;
    @(negedge clk);
    if (who) begin req1_valid = 1; req1_cs = cs; req1_data = d; end
    else     begin req0_valid = 1; req0_cs = cs; req0_data = d; end
    #1 rdy = who ? req1_ready : req0_ready;
    while (lat < 500) begin
      @(negedge clk);
      if (lat == 0) begin req0_valid = 0; req1_valid = 0; csn_first = csn; end
      lat++;
      if (csn[cs] == 1'b0) csn_low++;
      if (rsp_valid) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (csn !== 8'hFF) begin failures++; $display("FAIL reset_csn got=%h exp=ff", csn); end
    checks++; if (sclk !== 1'b0 || mosi !== 1'b0) begin failures++; $display("FAIL reset_pins sclk=%b mosi=%b exp=0", sclk, mosi); end
    checks++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0) begin failures++; $display("FAIL reset_rsp valid=%b id=%b exp=0", rsp_valid, rsp_id); end
    checks++; if (rsp_data !== '0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (csn6 !== 6'h3F) begin failures++; $display("FAIL reset_csn6 got=%h exp=3f", csn6); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready); end
  endtask

  task automatic test_basic();
    int lat, csn_low; bit rdy; logic [7:0] cf;
    run_txn(1'b0, 3'd2, 16'hA55A, 16'h3C96, lat, rdy, csn_low, cf);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", rdy); end
    checks++; if (cf !== 8'b11111011) begin failures++; $display("FAIL basic_csn got=%b exp=11111011", cf); end
    checks++; if (csn_low != CSN_LOW) begin failures++; $display("FAIL basic_csn_len got=%0d exp=%0d", csn_low, CSN_LOW); end
    checks++; if (lat != LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (mosi_cap !== 16'hA55A) begin failures++; $display("FAIL basic_mosi got=%h exp=a55a", mosi_cap); end
    checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL basic_rsp_id got=%b exp=0", rsp_id); end
    checks++; if (rsp_data !== 16'h3C96) begin failures++; $display("FAIL basic_rsp_data got=%h exp=3c96", rsp_data); end
    checks++; if (csn !== 8'hFF || mosi !== 1'b0 || sclk !== 1'b0) begin failures++; $display("FAIL basic_gap_pins csn=%h mosi=%b sclk=%b exp=ff/0/0", csn, mosi, sclk); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse_width got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 16'h3C96) begin failures++; $display("FAIL basic_rsp_hold got=%h exp=3c96", rsp_data); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_gap got=%b exp=1", busy); end
    repeat (CD) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b exp=0", busy); end
  endtask

  task automatic test_lone_req1();
    int lat, csn_low; bit rdy; logic [7:0] cf;
    run_txn(1'b1, 3'd5, 16'h0F0F, 16'h8001, lat, rdy, csn_low, cf);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL req1_ready got=%b exp=1", rdy); end
    checks++; if (cf !== 8'b11011111) begin failures++; $display("FAIL req1_csn got=%b exp=11011111", cf); end
    checks++; if (csn_low != CSN_LOW) begin failures++; $display("FAIL req1_csn_len got=%0d exp=%0d", csn_low, CSN_LOW); end
    checks++; if (rsp_id !== 1'b1) begin failures++; $display("FAIL req1_rsp_id got=%b exp=1", rsp_id); end
    checks++; if (rsp_data !== 16'h8001) begin failures++; $display("FAIL req1_rsp_data got=%h exp=8001", rsp_data); end
    checks++; if (mosi_cap !== 16'h0F0F) begin failures++; $display("FAIL req1_mosi got=%h exp=0f0f", mosi_cap); end
    repeat (CD + 1) @(negedge clk);
  endtask

  task automatic test_bad_cs();
    int lat; bit all_high;
    lat = 0; all_high = 1;
    slave_word = 16'hFFFF; bit_idx = 0;
    @(negedge clk);
    r0v6 = 1; r0cs6 = 3'd7; r0d6 = 16'hA5A5;
    #1 checks++; if (r0r6 !== 1'b1) begin failures++; $display("FAIL badcs_ready got=%b exp=1", r0r6); end
    while (lat < 500) begin
      @(negedge clk);
      r0v6 = 0;
      lat++;
      if (csn6 !== 6'h3F) all_high = 0;
      if (rv6) break;
    end
    checks++; if (!all_high) begin failures++; $display("FAIL badcs_csn got=not_all_high exp=111111"); end
    checks++; if (lat != LAT) begin failures++; $display("FAIL badcs_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (rd6 !== '0) begin failures++; $display("FAIL badcs_rsp_data got=%h exp=0", rd6); end
    repeat (CD + 1) @(negedge clk);
  endtask

  task automatic test_arbitration();
    int cyc;
    do_reset();
    exp_q.delete(); got_q.delete();
`ifdef DX_SPI_CTRL_RR_EN
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
`else
    exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b0);
`endif
    slave_word = '0; bit_idx = 0;
    @(negedge clk);
    req0_valid = 1; req0_cs = 3'd1; req0_data = 16'h1111;
    req1_valid = 1; req1_cs = 3'd4; req1_data = 16'h2222;
    cyc = 0;
    while (got_q.size() < 3 && cyc < 1000) begin
      #1;
      if (req0_valid && req0_ready) got_q.push_back(1'b0);
      if (req1_valid && req1_ready) got_q.push_back(1'b1);
      @(negedge clk);
      cyc++;
    end
    req0_valid = 0; req1_valid = 0;
    checks++; if (got_q.size() != 3) begin failures++; $display("FAIL arb_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL arb_order[%0d] got=%b exp=%b", i, (i < got_q.size()) ? got_q[i] : 1'bx, exp_q[i]);
      end
    end
    cyc = 0;
    while (busy && cyc < 200) begin @(negedge clk); cyc++; end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arb_drain got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int cyc, pulses, lat, csn_low; bit rdy; logic [7:0] cf;
    do_reset();
    slave_word = 16'h1234; bit_idx = 0; rise_cnt = 0;
    @(negedge clk);
    req0_valid = 1; req0_cs = 3'd2; req0_data = 16'hFFFF;
    @(negedge clk);
    req0_valid = 0;
    cyc = 0;
    while (rise_cnt < 9 && cyc < 200) begin @(negedge clk); cyc++; end
    checks++; if (sclk !== 1'b1 || mosi !== 1'b1) begin failures++; $display("FAIL mid_pre sclk=%b mosi=%b exp=1/1", sclk, mosi); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (csn !== 8'hFF) begin failures++; $display("FAIL mid_csn got=%h exp=ff", csn); end
    checks++; if (sclk !== 1'b0 || mosi !== 1'b0) begin failures++; $display("FAIL mid_pins sclk=%b mosi=%b exp=0/0", sclk, mosi); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (LAT + 10) begin @(negedge clk); if (rsp_valid) pulses++; end
    checks++; if (pulses != 0) begin failures++; $display("FAIL mid_no_rsp got=%0d exp=0", pulses); end
    run_txn(1'b0, 3'd6, 16'h3C3C, 16'hBEEF, lat, rdy, csn_low, cf);
    checks++; if (lat != LAT) begin failures++; $display("FAIL mid_next_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (rsp_data !== 16'hBEEF || rsp_id !== 1'b0) begin failures++; $display("FAIL mid_next_rsp got=%h/%b exp=beef/0", rsp_data, rsp_id); end
    checks++; if (mosi_cap !== 16'h3C3C) begin failures++; $display("FAIL mid_next_mosi got=%h exp=3c3c", mosi_cap); end
    repeat (CD + 1) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lone_req1();
    test_bad_cs();
    test_arbitration();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
